// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display datapath: digit type, segment codes, limits.
package bcd_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_t;

  localparam bcd_digit_t BCD_ZERO = 4'd0;
  localparam bcd_digit_t BCD_NINE = 4'd9;

  // Active-high segments, bit0 = a ... bit6 = g
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7.sv
// BCD to 7-segment decoder, active-high, bit0 = a ... bit6 = g. Non-decimal codes go blank.
module seg7
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output seg_t       segments
);

  // Pure lookup
  always_comb begin
    segments = SEG_BLANK;
    case (digit)
      4'd0:    segments = SEG_0;
      4'd1:    segments = SEG_1;
      4'd2:    segments = SEG_2;
      4'd3:    segments = SEG_3;
      4'd4:    segments = SEG_4;
      4'd5:    segments = SEG_5;
      4'd6:    segments = SEG_6;
      4'd7:    segments = SEG_7;
      4'd8:    segments = SEG_8;
      4'd9:    segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_gen.sv
// Generic divide-by-Div pulse generator. The pulse is high in the cycle the counter sits
// at Div-1 while enabled; clear restarts the count and suppresses the pulse.
module tick_gen #(
  parameter int unsigned Div = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic pulse
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;
  logic            at_last;

  assign at_last = (cnt_q == CntLast);
  assign pulse   = en & ~clear & at_last;

  // Divider counter: holds while disabled, restarts on clear
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= at_last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down tick counter with a time-multiplexed 7-segment output.
// Optional build macro BLANK_LEADING_EN: blank leading-zero digits above digit 0.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned SCAN_DIV   = 10_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    up,
  input  logic                    clear,
  output logic                    tick,
  output logic                    wrap,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BcdW-1:0]       bcd_q, bcd_d;
  logic                  wrap_q;
  logic                  carry;
  bcd_digit_t            cur_digit;

  logic                  scan_step;
  logic [IdxW-1:0]       idx_q, idx_d;
  bcd_digit_t            sel_digit;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] sel_onehot;
  seg_t                  seg_raw, seg_next;
  seg_t                  segments_q;
  logic [NUM_DIGITS-1:0] digit_sel_q;

  tick_gen #(
    .Div (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .clear (clear),
    .pulse (tick)
  );

  tick_gen #(
    .Div (SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clear (1'b0),
    .pulse (scan_step)
  );

  // Ripple increment/decrement across the decades; carry out of the top digit means wrap
  always_comb begin
    bcd_d     = bcd_q;
    carry     = 1'b1;
    cur_digit = BCD_ZERO;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      cur_digit = bcd_q[4*k +: 4];
      if (carry) begin
        if (up) begin
          if (cur_digit == BCD_NINE) begin
            bcd_d[4*k +: 4] = BCD_ZERO;
          end else begin
            bcd_d[4*k +: 4] = cur_digit + 4'd1;
            carry           = 1'b0;
          end
        end else begin
          if (cur_digit == BCD_ZERO) begin
            bcd_d[4*k +: 4] = BCD_NINE;
          end else begin
            bcd_d[4*k +: 4] = cur_digit - 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  // Count register; tick is already suppressed by clear inside the prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else if (clear) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tick & carry;
      if (tick) begin
        bcd_q <= bcd_d;
      end
    end
  end

  // Next scan index, wrapping at the last digit
  always_comb begin
    idx_d = idx_q;
    if (scan_step) begin
      if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

`ifdef BLANK_LEADING_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;

  // lead_zero[k]: digit k and every digit above it are zero
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run     = zero_run & (bcd_q[4*k +: 4] == BCD_ZERO);
      lead_zero[k] = zero_run;
    end
  end
`endif

  // Select the digit shown at the next index, plus its one-hot enable
  always_comb begin
    sel_digit  = BCD_ZERO;
    sel_blank  = 1'b0;
    sel_onehot = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      sel_onehot[k] = (idx_d == IdxW'(k));
      if (idx_d == IdxW'(k)) begin
        sel_digit = bcd_q[4*k +: 4];
`ifdef BLANK_LEADING_EN
        sel_blank = (k != 0) && lead_zero[k];
`endif
      end
    end
  end

  seg7 u_seg7 (
    .digit    (sel_digit),
    .segments (seg_raw)
  );

  assign seg_next = sel_blank ? SEG_BLANK : seg_raw;

  // Segments and digit enable share one register stage so they never disagree
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      segments_q  <= SEG_0;
      digit_sel_q <= NUM_DIGITS'(1);
    end else begin
      idx_q       <= idx_d;
      segments_q  <= seg_next;
      digit_sel_q <= sel_onehot;
    end
  end

  assign wrap      = wrap_q;
  assign bcd       = bcd_q;
  assign segments  = segments_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Parametrised multi-digit BCD up/down seconds counter with time-multiplexed 7-segment output. Divides the system clock into a tick, counts ticks in NUM_DIGITS cascaded decades, and scans one digit at a time onto a shared segment bus with a one-hot digit select. It sits between the top-level pin wrapper and the display, replacing the single-digit counter.

## Interface
- NUM_DIGITS, 4: number of BCD decades; legal range 1..8.
- TICK_DIV, 24'd10_000_000: clock cycles per count tick; legal range 2..2^24.
- SCAN_DIV, 16'd10_000: clock cycles per digit-scan step; legal range 1..2^16.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  1 = prescaler advances; 0 = prescaler and count hold.
- up  input  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clear  input  1  synchronous clear of count and prescaler; no effect on the scan.
- tick  output  1  one-cycle pulse per TICK_DIV cycles while run=1.
- wrap  output  1  one-cycle pulse when the count wraps (max→0 up, 0→max down).
- bcd  output  4*NUM_DIGITS  current count; digit k at bits [4k+3:4k], digit 0 least significant.
- segments  output  7  segment pattern of the selected digit; bit0=a … bit6=g, active-high.
- digit_sel  output  NUM_DIGITS  one-hot, active-high digit enable.

## Operation
- Prescaler: counts 0..TICK_DIV-1 while run=1. tick=1 exactly in the cycle the prescaler equals TICK_DIV-1 and run=1. The prescaler then returns to 0.
- Count update on a tick, registered: the new bcd is visible on the cycle after tick.
  - up=1: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - up=0: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Full-range wrap: 10^NUM_DIGITS-1 → 0 (up) or 0 → 10^NUM_DIGITS-1 (down). wrap pulses in the same cycle bcd takes the wrapped value.
- Priority: reset > clear > tick. clear zeroes bcd and the prescaler and suppresses tick/wrap that cycle.
- Scan: the scan counter runs 0..SCAN_DIV-1 regardless of run. On reaching terminal it advances the digit index, wrapping NUM_DIGITS-1 → 0. NUM_DIGITS=1 keeps digit_sel=1 permanently.
- segments is the seg7 decoding of bcd digit[index]. segments and digit_sel are registered together and always update in the same cycle (no ghosting).
- Codes 0..9 only. The datapath never produces 10..15.

## Timing
- Reset values: bcd=0, tick=0, wrap=0, digit_sel=1 (digit 0), segments=7'h3F ("0"), prescaler=0, scan counter=0.
- First tick occurs TICK_DIV cycles after reset deasserts, with run=1 throughout.
- tick → bcd latency: 1 cycle.
- Scan step → segments/digit_sel latency: 1 cycle. Each digit is held SCAN_DIV cycles.
- run deasserted mid-period: the prescaler freezes and resumes from the same value. Ticks are not lost or duplicated.
- up changing between ticks: only the value present on the tick cycle matters.
- clear and tick in the same cycle: clear wins, and the prescaler restarts from 0.

## Configuration
- BLANK_LEADING_EN defined:
  - Any digit k>0 whose value and all higher digits are 0 drives segments=7'h00 while selected.
  - Digit 0 is never blanked.
  - digit_sel scanning is unchanged.
- Undefined: all digits are displayed, including leading zeros.

## Structure
- Shared package bcd_pkg holds:
  - the segment encoding constants SEG_0..SEG_9 and SEG_BLANK;
  - the BCD digit typedef (4 bits);
  - MAX_DIGITS=8.
- Sub-module tick_gen: generic divide-by-N pulse generator with enable. It is instantiated twice, for the prescaler (gated by run and clear) and for the scan (always enabled).
- The existing seg7 decoder is reused for the segment lookup.

## Test plan
All scenarios use NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2 unless stated.
- Reset, then run=1, up=1 → tick every 4 cycles starting cycle 4. bcd reads 0x01 on cycle 5 and 0x10 after 10 ticks.
- Count up from 0x99 → next tick gives bcd=0x00 with wrap=1 for exactly one cycle.
- up=0 from 0x00 → bcd=0x99 with wrap=1. A further tick gives 0x98.
- run=0 for 10 cycles mid-period → no tick. The period resumes from the held prescaler value, and total ticks over the run=1 cycles are unchanged.
- clear asserted in the tick cycle at bcd=0x37 → bcd=0x00, no tick or wrap, next tick 4 cycles after clear deasserts.
- Scan with bcd=0x05:
  - digit_sel alternates 01/10 every 2 cycles, with segments=SEG_5 on 01.
  - On 10, segments=SEG_0, or 7'h00 with BLANK_LEADING_EN.
